jump_unit_ras: RTL and testbench
================================

JUMP_UNIT_RAS -- requirements
Module: jump_unit_ras

Interface
REQ-001 Parameter ADDR_W, default 32, address/data width of pc, targets, link values and RAS entries.
REQ-002 Parameter RAS_DEPTH, default 8, return-address-stack entries; power of two, at least 2.
REQ-003 Parameter LINK_OFFSET, default 8, link value added to pc (branch delay slot).
REQ-004 Parameter MISS_CNT_W, default 16, width of the mispredict counter.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 inst_valid  in  1  ID holds a live instruction.
REQ-008 stall  in  1  pipeline stall; state frozen.
REQ-009 pc  in  ADDR_W  pc of the ID instruction.
REQ-010 inst  in  32  instruction word.
REQ-011 rs_data  in  ADDR_W  forwarded rs register value.
REQ-012 inst_j  out  1  instruction is J, JAL, JR or JALR.
REQ-013 branch_flag, branch_addr  out  1, ADDR_W  redirect request and target to pc.
REQ-014 operand_1, operand_2  out  ADDR_W  link value and zero, to EX.
REQ-015 write_reg_en, write_reg_addr  out  1, 5  link register write.
REQ-016 ras_pred_valid, ras_pred_addr  out  1, ADDR_W  RAS top-of-stack prediction.
REQ-017 ras_mispredict  out  1  return target differs from prediction, or RAS empty on return.
REQ-018 ras_count  out  clog2(RAS_DEPTH)+1  valid entries.
REQ-019 miss_count  out  MISS_CNT_W  saturating mispredict counter.

Function
REQ-020 Decode: J op 000010, JAL op 000011, JR op 000000/funct 001000, JALR op 000000/funct 001001; any other instruction, or inst_valid=0, drives all decode outputs to 0.
REQ-021 J/JAL target = {(pc+4)[ADDR_W-1:28], inst[25:0], 2'b00}; JR/JALR target = rs_data; branch_flag=1 for all four.
REQ-022 JAL: operand_1=pc+LINK_OFFSET, write_reg_en=1, write_reg_addr=31; JALR: same link, write_reg_addr=inst[15:11]; J/JR: operand_1=0, write_reg_en=0.
REQ-023 operand_2 is always 0; decode/target outputs are combinational with zero latency.
REQ-024 Push = JAL, or JALR with rd=31; pop = JR or JALR with rs (inst[25:21])=31; both only when inst_valid=1 and stall=0; state updates on the next rising edge.
REQ-025 Push writes pc+LINK_OFFSET at the top pointer, increments the pointer modulo RAS_DEPTH, ras_count saturates at RAS_DEPTH; push when full overwrites the oldest entry.
REQ-026 Pop decrements the pointer modulo RAS_DEPTH and ras_count; pop when empty changes nothing.
REQ-027 Simultaneous push and pop: the top entry is replaced with the new link value; pointer and ras_count unchanged; if empty, it behaves as a push.
REQ-028 ras_pred_valid = (ras_count!=0); ras_pred_addr = top entry, 0 when empty.
REQ-029 ras_mispredict = pop qualifier AND (empty OR ras_pred_addr != rs_data), combinational.
REQ-030 miss_count increments on each clock with ras_mispredict=1 and stall=0, and saturates at all-ones.
REQ-031 stall=1 holds the pointer, ras_count, entries and miss_count; combinational outputs still reflect the inputs.

Reset
REQ-032 On rst=1 at a rising edge: pointer=0, ras_count=0, miss_count=0, all entries=0.
REQ-033 While rst=1, every output is forced to 0, including ras_pred_valid and ras_mispredict.
REQ-034 rst overrides any concurrent push, pop or stall.

Structure
REQ-035 Opcode/funct values, register index 31 and segment positions belong in the shared define headers, not local literals.
REQ-036 The stack is one sub-module, ras_stack (push, pop, top, count), parametrised by ADDR_W and RAS_DEPTH; decode stays in jump_unit_ras.

Verification
REQ-037 JAL at pc=0x00400000, inst[25:0]=0x0000010 -> branch_addr=0x00000040, operand_1=0x00400008, write_reg_addr=31, ras_count 0->1, top=0x00400008.
REQ-038 After REQ-037, JR $31 with rs_data=0x00400008 -> ras_mispredict=0, ras_count 1->0; repeat with rs_data=0x00400010 -> ras_mispredict=1, miss_count=1.
REQ-039 Ten JALs at pc=0x100, 0x200 ... 0xA00 (depth 8) -> ras_count=8; eight pops return 0xA08 down to 0x308; the ninth pop -> ras_mispredict=1, ras_count stays 0.
REQ-040 JALR rs=31, rd=31 at pc=0x500 with one entry 0x108 -> ras_mispredict follows rs_data compared with 0x108, top becomes 0x508, ras_count stays 1.
REQ-041 JAL with stall=1 -> branch outputs valid, ras_count unchanged; rst asserted mid-sequence with three entries -> ras_count=0, miss_count=0 next cycle.

Source files
------------

// File: rtl/jump_unit_ras_pkg.sv
// Shared jump decode constants and helpers for the ID-stage jump unit and its RAS.
package jump_unit_ras_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;

    localparam logic [4:0] REG_RA = 5'd31;

    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned JIDX_W  = 26;
    localparam int unsigned SEG_LSB = 28;

    typedef enum logic [2:0] {
        JK_NONE,
        JK_J,
        JK_JAL,
        JK_JR,
        JK_JALR
    } jump_kind_e;

    function automatic jump_kind_e decode_jump(input logic [31:0] inst);
        logic [5:0] op;
        logic [5:0] funct;
        op    = inst[OP_LSB +: 6];
        funct = inst[5:0];
        if (op == OP_J)
            return JK_J;
        else if (op == OP_JAL)
            return JK_JAL;
        else if (op == OP_SPECIAL && funct == FUNCT_JR)
            return JK_JR;
        else if (op == OP_SPECIAL && funct == FUNCT_JALR)
            return JK_JALR;
        else
            return JK_NONE;
    endfunction

endpackage

// File: rtl/jump_unit_ras_stack.sv
// Circular return-address stack: push, pop, replace-top on push+pop, overwrite oldest when full.
module ras_stack #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_m1;
    logic              empty;
    logic              full;

    assign ptr_m1 = ptr - PTR_W'(1);
    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(RAS_DEPTH));
    assign top    = empty ? '0 : mem[ptr_m1];

    // ptr always addresses the next free slot, which is the oldest entry once full
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++)
                mem[i] <= '0;
        end else if (push && pop && !empty) begin
            mem[ptr_m1] <= push_data;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + PTR_W'(1);
            if (!full)
                count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr_m1;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/jump_unit_ras.sv
// ID-stage jump decode with link generation and return-address-stack prediction.
module jump_unit_ras
    import jump_unit_ras_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned RAS_DEPTH   = 8,
    parameter int unsigned LINK_OFFSET = 8,
    parameter int unsigned MISS_CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inst_valid,
    input  logic                        stall,
    input  logic [ADDR_W-1:0]           pc,
    input  logic [31:0]                 inst,
    input  logic [ADDR_W-1:0]           rs_data,
    output logic                        inst_j,
    output logic                        branch_flag,
    output logic [ADDR_W-1:0]           branch_addr,
    output logic [ADDR_W-1:0]           operand_1,
    output logic [ADDR_W-1:0]           operand_2,
    output logic                        write_reg_en,
    output logic [4:0]                  write_reg_addr,
    output logic                        ras_pred_valid,
    output logic [ADDR_W-1:0]           ras_pred_addr,
    output logic                        ras_mispredict,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic [MISS_CNT_W-1:0]       miss_count
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    jump_kind_e            kind;
    logic [4:0]            rs_idx;
    logic [4:0]            rd_idx;
    logic [ADDR_W-1:0]     pc_plus4;
    logic [ADDR_W-1:0]     link;
    logic [ADDR_W-1:0]     j_target;
    logic                  live;
    logic                  push;
    logic                  pop;
    logic                  mispredict_raw;
    logic [ADDR_W-1:0]     stk_top;
    logic [CNT_W-1:0]      stk_count;
    logic [MISS_CNT_W-1:0] miss_q;
    logic                  unused_pc_low;

    assign kind          = inst_valid ? decode_jump(inst) : JK_NONE;
    assign rs_idx        = inst[RS_LSB +: 5];
    assign rd_idx        = inst[RD_LSB +: 5];
    assign pc_plus4      = pc + ADDR_W'(4);
    assign link          = pc + ADDR_W'(LINK_OFFSET);
    assign j_target      = {pc_plus4[ADDR_W-1:SEG_LSB], inst[JIDX_W-1:0], 2'b00};
    assign unused_pc_low = ^pc_plus4[SEG_LSB-1:0];

    // Stack traffic only advances on an unstalled live instruction
    assign live = inst_valid && !stall;
    assign push = live && (kind == JK_JAL || (kind == JK_JALR && rd_idx == REG_RA));
    assign pop  = live && (kind == JK_JR || kind == JK_JALR) && rs_idx == REG_RA;

    assign mispredict_raw = pop && (stk_count == '0 || stk_top != rs_data);

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (link),
        .top       (stk_top),
        .count     (stk_count)
    );

    always_ff @(posedge clk) begin
        if (rst)
            miss_q <= '0;
        else if (mispredict_raw && miss_q != '1)
            miss_q <= miss_q + MISS_CNT_W'(1);
    end

    // Decode outputs; everything reads zero while reset is held
    always_comb begin
        inst_j         = 1'b0;
        branch_flag    = 1'b0;
        branch_addr    = '0;
        operand_1      = '0;
        operand_2      = '0;
        write_reg_en   = 1'b0;
        write_reg_addr = '0;
        if (!rst) begin
            case (kind)
                JK_J: begin
                    inst_j      = 1'b1;
                    branch_flag = 1'b1;
                    branch_addr = j_target;
                end
                JK_JAL: begin
                    inst_j         = 1'b1;
                    branch_flag    = 1'b1;
                    branch_addr    = j_target;
                    operand_1      = link;
                    write_reg_en   = 1'b1;
                    write_reg_addr = REG_RA;
                end
                JK_JR: begin
                    inst_j      = 1'b1;
                    branch_flag = 1'b1;
                    branch_addr = rs_data;
                end
                JK_JALR: begin
                    inst_j         = 1'b1;
                    branch_flag    = 1'b1;
                    branch_addr    = rs_data;
                    operand_1      = link;
                    write_reg_en   = 1'b1;
                    write_reg_addr = rd_idx;
                end
                default: ;
            endcase
        end
    end

    assign ras_pred_valid = !rst && stk_count != '0;
    assign ras_pred_addr  = rst ? '0 : stk_top;
    assign ras_mispredict = !rst && mispredict_raw;
    assign ras_count      = rst ? '0 : stk_count;
    assign miss_count     = rst ? '0 : miss_q;

endmodule

// File: tb/tb_jump_unit_ras.sv
// Directed self-checking bench for jump_unit_ras with default parameters.
module tb_jump_unit_ras;

    localparam logic [31:0] I_JAL16  = 32'h0C00_0010;
    localparam logic [31:0] I_JAL40  = 32'h0C00_0040;
    localparam logic [31:0] I_JR31   = 32'h03E0_0008;
    localparam logic [31:0] I_JALRRA = 32'h03E0_F809;
    localparam logic [31:0] I_JALR47 = 32'h0080_3809;
    localparam logic [31:0] I_J16    = 32'h0800_0010;
    localparam logic [31:0] I_ADD    = 32'h0000_0020;

    logic        clk;
    logic        rst;
    logic        inst_valid;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs_data;
    logic        inst_j;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        write_reg_en;
    logic [4:0]  write_reg_addr;
    logic        ras_pred_valid;
    logic [31:0] ras_pred_addr;
    logic        ras_mispredict;
    logic [3:0]  ras_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_pass   = 0;

    jump_unit_ras dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid     (inst_valid),
        .stall          (stall),
        .pc             (pc),
        .inst           (inst),
        .rs_data        (rs_data),
        .inst_j         (inst_j),
        .branch_flag    (branch_flag),
        .branch_addr    (branch_addr),
        .operand_1      (operand_1),
        .operand_2      (operand_2),
        .write_reg_en   (write_reg_en),
        .write_reg_addr (write_reg_addr),
        .ras_pred_valid (ras_pred_valid),
        .ras_pred_addr  (ras_pred_addr),
        .ras_mispredict (ras_mispredict),
        .ras_count      (ras_count),
        .miss_count     (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_in(input logic v, input logic [31:0] p, input logic [31:0] i,
                          input logic [31:0] r, input logic s);
        inst_valid = v;
        pc         = p;
        inst       = i;
        rs_data    = r;
        stall      = s;
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] p, input logic [31:0] i, input logic [31:0] r);
        set_in(1'b1, p, i, r, 1'b0);
        tick();
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] exp_a;
        rst = 1'b1;
        idle();

        // Reset state, with a live JAL on the inputs that must be masked
        set_in(1'b1, 32'h0040_0000, I_JAL16, 32'h0, 1'b0);
        chk("rst_branch_flag", 64'(branch_flag), 64'd0);
        chk("rst_inst_j", 64'(inst_j), 64'd0);
        chk("rst_operand_1", 64'(operand_1), 64'd0);
        tick();
        chk("rst_ras_count", 64'(ras_count), 64'd0);
        chk("rst_pred_valid", 64'(ras_pred_valid), 64'd0);
        chk("rst_miss_count", 64'(miss_count), 64'd0);
        rst = 1'b0;
        idle();
        tick();
        chk("post_rst_count", 64'(ras_count), 64'd0);

        // JAL then correct JR $31
        set_in(1'b1, 32'h0040_0000, I_JAL16, 32'h0, 1'b0);
        chk("jal_inst_j", 64'(inst_j), 64'd1);
        chk("jal_branch_flag", 64'(branch_flag), 64'd1);
        chk("jal_branch_addr", 64'(branch_addr), 64'h0000_0040);
        chk("jal_operand_1", 64'(operand_1), 64'h0040_0008);
        chk("jal_operand_2", 64'(operand_2), 64'd0);
        chk("jal_wen", 64'(write_reg_en), 64'd1);
        chk("jal_waddr", 64'(write_reg_addr), 64'd31);
        tick();
        idle();
        chk("jal_count", 64'(ras_count), 64'd1);
        chk("jal_pred_valid", 64'(ras_pred_valid), 64'd1);
        chk("jal_top", 64'(ras_pred_addr), 64'h0040_0008);

        set_in(1'b1, 32'h0000_0040, I_JR31, 32'h0040_0008, 1'b0);
        chk("jr_ok_mispredict", 64'(ras_mispredict), 64'd0);
        chk("jr_branch_addr", 64'(branch_addr), 64'h0040_0008);
        chk("jr_wen", 64'(write_reg_en), 64'd0);
        chk("jr_operand_1", 64'(operand_1), 64'd0);
        tick();
        idle();
        chk("jr_ok_count", 64'(ras_count), 64'd0);
        chk("jr_ok_miss", 64'(miss_count), 64'd0);
        chk("jr_ok_pred_valid", 64'(ras_pred_valid), 64'd0);

        // Repeat with a wrong return address, then a return on an empty stack
        issue(32'h0040_0000, I_JAL16, 32'h0);
        set_in(1'b1, 32'h0000_0040, I_JR31, 32'h0040_0010, 1'b0);
        chk("jr_bad_mispredict", 64'(ras_mispredict), 64'd1);
        tick();
        idle();
        chk("jr_bad_miss", 64'(miss_count), 64'd1);
        chk("jr_bad_count", 64'(ras_count), 64'd0);
        set_in(1'b1, 32'h0000_0040, I_JR31, 32'h0040_0010, 1'b0);
        chk("jr_empty_mispredict", 64'(ras_mispredict), 64'd1);
        chk("jr_empty_pred_addr", 64'(ras_pred_addr), 64'd0);
        tick();
        idle();
        chk("jr_empty_miss", 64'(miss_count), 64'd2);
        chk("jr_empty_count", 64'(ras_count), 64'd0);

        // J takes the segment from pc+4, not pc
        set_in(1'b1, 32'h1FFF_FFFC, I_J16, 32'h0, 1'b0);
        chk("j_branch_addr", 64'(branch_addr), 64'h2000_0040);
        chk("j_wen", 64'(write_reg_en), 64'd0);
        chk("j_operand_1", 64'(operand_1), 64'd0);
        // JALR with rd=7, rs=4: no stack traffic
        set_in(1'b1, 32'h0000_1000, I_JALR47, 32'h0000_1234, 1'b0);
        chk("jalr_branch_addr", 64'(branch_addr), 64'h0000_1234);
        chk("jalr_operand_1", 64'(operand_1), 64'h0000_1008);
        chk("jalr_waddr", 64'(write_reg_addr), 64'd7);
        chk("jalr_mispredict", 64'(ras_mispredict), 64'd0);
        tick();
        idle();
        chk("jalr_count", 64'(ras_count), 64'd0);
        // Non-jump and invalid instruction
        set_in(1'b1, 32'h0000_1000, I_ADD, 32'h0, 1'b0);
        chk("add_inst_j", 64'(inst_j), 64'd0);
        chk("add_branch_flag", 64'(branch_flag), 64'd0);
        set_in(1'b0, 32'h0000_1000, I_JAL16, 32'h0, 1'b0);
        chk("invalid_branch_flag", 64'(branch_flag), 64'd0);
        chk("invalid_wen", 64'(write_reg_en), 64'd0);
        tick();
        idle();
        chk("invalid_count", 64'(ras_count), 64'd0);

        // Overflow: ten pushes into eight entries, then drain
        do_reset();
        for (int k = 1; k <= 10; k++)
            issue(32'(k) << 8, I_JAL40, 32'h0);
        chk("ovf_count", 64'(ras_count), 64'd8);
        chk("ovf_top", 64'(ras_pred_addr), 64'h0000_0A08);
        for (int k = 10; k >= 3; k--) begin
            exp_a = (32'(k) << 8) + 32'h8;
            set_in(1'b1, 32'h0, I_JR31, exp_a, 1'b0);
            chk($sformatf("drain_top_%0d", k), 64'(ras_pred_addr), 64'(exp_a));
            chk($sformatf("drain_mis_%0d", k), 64'(ras_mispredict), 64'd0);
            tick();
            idle();
        end
        chk("drain_count", 64'(ras_count), 64'd0);
        set_in(1'b1, 32'h0, I_JR31, 32'h0000_0308, 1'b0);
        chk("drain_ninth_mis", 64'(ras_mispredict), 64'd1);
        tick();
        idle();
        chk("drain_ninth_count", 64'(ras_count), 64'd0);
        chk("drain_ninth_miss", 64'(miss_count), 64'd1);

        // JALR $31,$31: replace top, count unchanged
        do_reset();
        issue(32'h0000_0100, I_JAL40, 32'h0);
        set_in(1'b1, 32'h0000_0500, I_JALRRA, 32'h0000_0108, 1'b0);
        chk("swap_mis_ok", 64'(ras_mispredict), 64'd0);
        chk("swap_operand_1", 64'(operand_1), 64'h0000_0508);
        chk("swap_waddr", 64'(write_reg_addr), 64'd31);
        tick();
        idle();
        chk("swap_count", 64'(ras_count), 64'd1);
        chk("swap_top", 64'(ras_pred_addr), 64'h0000_0508);
        set_in(1'b1, 32'h0000_0600, I_JALRRA, 32'h0000_0108, 1'b0);
        chk("swap_mis_bad", 64'(ras_mispredict), 64'd1);
        tick();
        idle();
        chk("swap2_count", 64'(ras_count), 64'd1);
        chk("swap2_top", 64'(ras_pred_addr), 64'h0000_0608);
        chk("swap2_miss", 64'(miss_count), 64'd1);

        // Stall freezes stack; reset mid-sequence clears everything
        do_reset();
        set_in(1'b1, 32'h0040_0000, I_JAL16, 32'h0, 1'b1);
        chk("stall_branch_flag", 64'(branch_flag), 64'd1);
        chk("stall_branch_addr", 64'(branch_addr), 64'h0000_0040);
        tick();
        idle();
        chk("stall_count", 64'(ras_count), 64'd0);
        for (int k = 1; k <= 3; k++)
            issue(32'(k) << 12, I_JAL40, 32'h0);
        chk("three_count", 64'(ras_count), 64'd3);
        issue(32'h0, I_JR31, 32'hDEAD_0000);
        chk("pre_rst_miss", 64'(miss_count), 64'd1);
        chk("pre_rst_count", 64'(ras_count), 64'd2);
        rst = 1'b1;
        set_in(1'b1, 32'h0040_0000, I_JAL16, 32'h0, 1'b0);
        chk("rst_mid_count", 64'(ras_count), 64'd0);
        chk("rst_mid_branch", 64'(branch_flag), 64'd0);
        chk("rst_mid_pred_valid", 64'(ras_pred_valid), 64'd0);
        tick();
        rst = 1'b0;
        idle();
        chk("rst_after_count", 64'(ras_count), 64'd0);
        chk("rst_after_miss", 64'(miss_count), 64'd0);
        chk("rst_after_pred_valid", 64'(ras_pred_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

endmodule
